// File: rtl/dlx_bus_pkg.sv
// Shared DLX bus helpers: word/lane sizes and the small combinational functions
// used by the gated bus collector (lane mask expansion, priority index, contention test).
package dlx_bus_pkg;

  localparam int DLX_WORD_W = 32;
  localparam int BYTE_W     = 8;
  localparam int MAX_CH     = 16;
  localparam int MAX_LANES  = 64;
  localparam int IDX_W      = 4;

  // Operates on the widest supported lane vector; callers zero-extend and truncate.
  function automatic logic [MAX_LANES*BYTE_W-1:0] lane_expand(input logic [MAX_LANES-1:0] be);
    logic [MAX_LANES*BYTE_W-1:0] m;
    m = '0;
    for (int k = 0; k < MAX_LANES; k++) begin
      m[k*BYTE_W +: BYTE_W] = {BYTE_W{be[k]}};
    end
    return m;
  endfunction

  function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_CH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_CH-1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  function automatic logic popcnt_ge2(input logic [MAX_CH-1:0] v);
    return (v & (v - MAX_CH'(1))) != '0;
  endfunction

endpackage

// File: rtl/gated_bus_collector_if.sv
// Bus bundle between the DLX result-bus sources and the gated bus collector.
// The master side drives source words and controls; the slave side is the collector.
interface gated_bus_collector_if
  import dlx_bus_pkg::*;
#(
  parameter int WIDTH = DLX_WORD_W,
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);
  localparam int LANES = WIDTH / BYTE_W;
  localparam int SRC_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*WIDTH-1:0] din;
  logic [NCH-1:0]       pull;
  logic [LANES-1:0]     byte_en;
  logic                 clr_sticky;
  logic [WIDTH-1:0]     dout;
  logic                 dout_valid;
  logic [SRC_W-1:0]     src_idx;
  logic                 conflict;
  logic                 conflict_sticky;
  logic [CNT_W-1:0]     conflict_cnt;

  modport master (
    output din, pull, byte_en, clr_sticky,
    input  dout, dout_valid, src_idx, conflict, conflict_sticky, conflict_cnt
  );

  modport slave (
    input  din, pull, byte_en, clr_sticky,
    output dout, dout_valid, src_idx, conflict, conflict_sticky, conflict_cnt
  );

endinterface

// File: rtl/gated_word.sv
// One pull-gated source word: the word passes only while its pull line is high,
// so several of these can be OR-combined into a wired-OR bus.
module gated_word #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pull,
  output logic [WIDTH-1:0] o_dout
);

  assign o_dout = i_din & {WIDTH{i_pull}};

endmodule

// File: rtl/gated_bus_collector.sv
// Registered wired-OR collector for the DLX internal result bus: gates NCH sources,
// applies a byte-lane mask and monitors multi-driver contention.
module gated_bus_collector
  import dlx_bus_pkg::*;
#(
  parameter int WIDTH     = DLX_WORD_W,
  parameter int NCH       = 4,
  parameter int HOLD_LAST = 0,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  gated_bus_collector_if.slave  bus
);

  localparam int LANES = WIDTH / BYTE_W;
  localparam int SRC_W = (NCH > 1) ? $clog2(NCH) : 1;

  if ((WIDTH % BYTE_W) != 0 || WIDTH < BYTE_W || LANES > MAX_LANES) begin : g_bad_width
    $error("gated_bus_collector: WIDTH must be a multiple of 8 in 8..512");
  end
  if (NCH < 1 || NCH > MAX_CH) begin : g_bad_nch
    $error("gated_bus_collector: NCH must be in 1..16");
  end

  logic [WIDTH-1:0]     w_gated [NCH];
  logic [WIDTH-1:0]     w_bus;
  logic [WIDTH-1:0]     w_masked;
  logic [MAX_LANES-1:0] w_be_ext;
  logic [MAX_CH-1:0]    w_pull_ext;
  logic                 w_any;
  logic                 w_conflict;
  logic [SRC_W-1:0]     w_lowest;

  logic [WIDTH-1:0]     r_dout_p1;
  logic                 r_vld_p1;
  logic [SRC_W-1:0]     r_src_idx_p1;
  logic                 r_conflict_p1;
  logic                 r_sticky;
  logic [CNT_W-1:0]     r_cnt;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    gated_word #(.WIDTH(WIDTH)) u_gated_word (
      .i_din  (bus.din[g*WIDTH +: WIDTH]),
      .i_pull (bus.pull[g]),
      .o_dout (w_gated[g])
    );
  end

  always_comb begin
    w_bus = '0;
    for (int i = 0; i < NCH; i++) begin
      w_bus = w_bus | w_gated[i];
    end
  end

  always_comb begin
    w_be_ext              = '0;
    w_be_ext[LANES-1:0]   = bus.byte_en;
    w_pull_ext            = '0;
    w_pull_ext[NCH-1:0]   = bus.pull;
  end

  assign w_masked   = w_bus & WIDTH'(lane_expand(w_be_ext));
  assign w_any      = |bus.pull;
  assign w_conflict = (NCH > 1) && popcnt_ge2(w_pull_ext);
  assign w_lowest   = (NCH > 1) ? SRC_W'(lowest_set(w_pull_ext)) : '0;

  // ---- stage p0 -> p1: output registers and contention monitor ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout_p1     <= '0;
      r_vld_p1      <= 1'b0;
      r_src_idx_p1  <= '0;
      r_conflict_p1 <= 1'b0;
      r_sticky      <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_vld_p1      <= w_any;
      r_conflict_p1 <= w_conflict;
      if (w_any) begin
        r_dout_p1    <= w_masked;
        r_src_idx_p1 <= w_lowest;
      end else if (HOLD_LAST == 0) begin
        r_dout_p1    <= '0;
        r_src_idx_p1 <= '0;
      end
      // A conflict in the same cycle as a clear restarts the count at one.
      if (w_conflict) begin
        r_sticky <= 1'b1;
        if (bus.clr_sticky) begin
          r_cnt <= CNT_W'(1);
        end else if (!(&r_cnt)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (bus.clr_sticky) begin
        r_sticky <= 1'b0;
        r_cnt    <= '0;
      end
    end
  end

  assign bus.dout            = r_dout_p1;
  assign bus.dout_valid      = r_vld_p1;
  assign bus.src_idx         = r_src_idx_p1;
  assign bus.conflict        = r_conflict_p1;
  assign bus.conflict_sticky = r_sticky;
  assign bus.conflict_cnt    = r_cnt;

endmodule
